// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped interval timer: register offsets,
// TCON bit positions and the TCON reset value.
package timer_pkg;

  // Byte offsets of the three registers relative to the base address.
  localparam logic [31:0] OFF_TH   = 32'd0;
  localparam logic [31:0] OFF_TL   = 32'd4;
  localparam logic [31:0] OFF_TCON = 32'd8;

  // TCON bit indices.
  localparam int RUN  = 0;
  localparam int IEN  = 1;
  localparam int STAT = 2;

  localparam logic [2:0] TCON_RST = 3'b000;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider for the interval timer: produces a one-cycle tick every
// PRESCALE cycles while run is high; holds at zero while stopped or cleared.
module timer_prescaler #(
  parameter int PRESCALE = 1,
  parameter int PS_W     = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] count;

  // Tick fires in the cycle the count reaches its last value.
  assign tick = run && (count == LAST);

  // Count up while running; wrap on tick, return to zero when stopped or cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!run || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/timer_irq_source.sv
// Memory-mapped interval timer. TL counts up on prescaler ticks, reloads
// from TH on overflow and latches a status flag that, together with the
// interrupt enable, drives a registered level interrupt.
//
// Bus semantics: mem_rd and mem_wr are single-cycle strobes with no
// back-pressure. A load is answered combinationally in the same cycle
// (rdata is zero unless mem_rd & hit); a store commits at the next rising
// edge when mem_wr & hit. Accesses that miss the decode are ignored.
module timer_irq_source
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRESCALE  = 1,
  parameter int          PS_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_rd,
  input  logic        mem_wr,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  logic [31:0] th, tl;
  logic [2:0]  tcon;
  logic [31:0] th_n, tl_n;
  logic [2:0]  tcon_n;
  logic        irq_n;
  logic        sel_th, sel_tl, sel_tcon;
  logic        wr_th, wr_tl, wr_tcon;
  logic        tick, overflow;

  // Full-address compare; any misaligned address simply misses.
  assign sel_th   = (addr == BASE_ADDR + OFF_TH);
  assign sel_tl   = (addr == BASE_ADDR + OFF_TL);
  assign sel_tcon = (addr == BASE_ADDR + OFF_TCON);
  assign hit      = sel_th | sel_tl | sel_tcon;

  assign wr_th   = mem_wr & sel_th;
  assign wr_tl   = mem_wr & sel_tl;
  assign wr_tcon = mem_wr & sel_tcon;

  assign overflow = tick && (tl == 32'hFFFF_FFFF);

  timer_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (tcon[RUN]),
    .clear (wr_tl),
    .tick  (tick)
  );

  // Load mux: selected register when reading a decoded address, else zero.
  always_comb begin
    rdata = 32'h0;
    if (mem_rd) begin
      if (sel_th)        rdata = th;
      else if (sel_tl)   rdata = tl;
      else if (sel_tcon) rdata = {29'b0, tcon};
    end
  end

  // Next-state for the register file and interrupt. A CPU write to TL wins
  // over count/reload; an overflow set of status wins over a software clear.
  always_comb begin
    th_n   = th;
    tl_n   = tl;
    tcon_n = tcon;
    if (wr_th) th_n = wdata;
    if (tick) tl_n = overflow ? th : tl + 32'd1;
    if (wr_tl) tl_n = wdata;
    if (wr_tcon) begin
      tcon_n[RUN] = wdata[0];
      tcon_n[IEN] = wdata[1];
      if (!wdata[2]) tcon_n[STAT] = 1'b0;
    end
    if (overflow && tcon[IEN]) tcon_n[STAT] = 1'b1;
    irq_n = tcon_n[STAT] & tcon_n[IEN];
  end

  // Register file and interrupt level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th   <= 32'h0;
      tl   <= 32'h0;
      tcon <= TCON_RST;
      irq  <= 1'b0;
    end else begin
      th   <= th_n;
      tl   <= tl_n;
      tcon <= tcon_n;
      irq  <= irq_n;
    end
  end

endmodule

// File: tb/tb_timer_irq_source.sv
// Directed bench for timer_irq_source: one instance with PRESCALE=1 for the
// register/overflow/interrupt behaviour and one with PRESCALE=4 for the
// prescaler. All bus inputs change in the low clock phase.
module tb_timer_irq_source;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_rd = 1'b0;
  logic        mem_wr0 = 1'b0;
  logic        mem_wr1 = 1'b0;
  logic [31:0] rdata0, rdata1;
  logic        hit0, hit1, irq0, irq1;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed running required finished");
    $fatal(1, "watchdog");
  end

  timer_irq_source #(.BASE_ADDR(32'h4000_0000), .PRESCALE(1), .PS_W(16)) dut0 (
    .clk(clk), .reset(rst), .addr(addr), .wdata(wdata), .mem_rd(mem_rd),
    .mem_wr(mem_wr0), .rdata(rdata0), .hit(hit0), .irq(irq0)
  );

  timer_irq_source #(.BASE_ADDR(32'h4000_0000), .PRESCALE(4), .PS_W(16)) dut1 (
    .clk(clk), .reset(rst), .addr(addr), .wdata(wdata), .mem_rd(mem_rd),
    .mem_wr(mem_wr1), .rdata(rdata1), .hit(hit1), .irq(irq1)
  );

  // Scoreboard compare.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Store: drive in the low phase, commit at the next posedge, return at the following negedge.
  task automatic wr(input int which, input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    if (which == 1) mem_wr1 = 1'b1;
    else            mem_wr0 = 1'b1;
    @(negedge clk);
    mem_wr0 = 1'b0;
    mem_wr1 = 1'b0;
  endtask

  // Load: combinational, sampled 1ns after driving the address.
  task automatic chk_rd(input string tag, input int which, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    addr   = a;
    mem_rd = 1'b1;
    #1;
    d = (which == 1) ? rdata1 : rdata0;
    mem_rd = 1'b0;
    check(tag, d, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    @(negedge clk);
    do_reset();

    // Reset values and decode.
    chk_rd("rst_th", 0, A_TH, 32'h0);
    chk_rd("rst_tl", 0, A_TL, 32'h0);
    chk_rd("rst_tcon", 0, A_TCON, 32'h0);
    check("rst_irq", {31'b0, irq0}, 32'h0);
    addr = A_TH;         #1; check("hit_th", {31'b0, hit0}, 32'd1);
    addr = A_TL;         #1; check("hit_tl", {31'b0, hit0}, 32'd1);
    addr = A_TCON;       #1; check("hit_tcon", {31'b0, hit0}, 32'd1);
    @(negedge clk);
    addr = 32'h4000_000C; #1; check("hit_0c", {31'b0, hit0}, 32'd0);
    addr = 32'h4000_0001; #1; check("hit_misalign", {31'b0, hit0}, 32'd0);
    mem_rd = 1'b1; addr = 32'h4000_000C; #1;
    check("rd_miss", rdata0, 32'h0);
    mem_rd = 1'b0;
    addr = A_TH; #1;
    check("rd_no_strobe", rdata0, 32'h0);
    @(negedge clk);

    // Count up to overflow with reload and interrupt.
    wr(0, A_TH, 32'hFFFF_FFFC);
    wr(0, A_TL, 32'hFFFF_FFFC);
    wr(0, A_TCON, 32'h3);
    chk_rd("a_tl_start", 0, A_TL, 32'hFFFF_FFFC);
    @(negedge clk); chk_rd("a_tl_fffd", 0, A_TL, 32'hFFFF_FFFD);
    @(negedge clk); chk_rd("a_tl_fffe", 0, A_TL, 32'hFFFF_FFFE);
    @(negedge clk); chk_rd("a_tl_ffff", 0, A_TL, 32'hFFFF_FFFF);
    check("a_irq_pre", {31'b0, irq0}, 32'd0);
    @(negedge clk);
    chk_rd("a_tl_reload", 0, A_TL, 32'hFFFF_FFFC);
    chk_rd("a_tcon_stat", 0, A_TCON, 32'h7);
    check("a_irq_set", {31'b0, irq0}, 32'd1);
    // Handler clears status.
    wr(0, A_TCON, 32'h3);
    chk_rd("b_tcon_clr", 0, A_TCON, 32'h3);
    check("b_irq_clr", {31'b0, irq0}, 32'd0);
    wr(0, A_TCON, 32'h0);

    // Writing status bit as 1 leaves it set; clearing irq_en drops irq only.
    do_reset();
    wr(0, A_TH, 32'hFFFF_FFFC);
    wr(0, A_TL, 32'hFFFF_FFFF);
    wr(0, A_TCON, 32'h3);
    @(negedge clk);
    chk_rd("c_tl_reload", 0, A_TL, 32'hFFFF_FFFC);
    check("c_irq_set", {31'b0, irq0}, 32'd1);
    wr(0, A_TCON, 32'h7);
    chk_rd("c_tcon_keep", 0, A_TCON, 32'h7);
    check("c_irq_keep", {31'b0, irq0}, 32'd1);
    wr(0, A_TCON, 32'h5);
    chk_rd("c_tcon_ien0", 0, A_TCON, 32'h5);
    check("c_irq_ien0", {31'b0, irq0}, 32'd0);

    // Status clear landing on the overflow edge: set wins.
    do_reset();
    wr(0, A_TH, 32'hFFFF_FFFC);
    wr(0, A_TL, 32'hFFFF_FFFE);
    wr(0, A_TCON, 32'h3);
    @(negedge clk);
    wr(0, A_TCON, 32'h3);
    chk_rd("d_tcon_setwins", 0, A_TCON, 32'h7);
    chk_rd("d_tl_reload", 0, A_TL, 32'hFFFF_FFFC);
    check("d_irq", {31'b0, irq0}, 32'd1);

    // TL write landing on the overflow edge: write wins, status still set.
    do_reset();
    wr(0, A_TH, 32'hFFFF_FFFC);
    wr(0, A_TL, 32'hFFFF_FFFE);
    wr(0, A_TCON, 32'h3);
    @(negedge clk);
    wr(0, A_TL, 32'h10);
    chk_rd("e_tl_write_wins", 0, A_TL, 32'h10);
    chk_rd("e_tcon_stat", 0, A_TCON, 32'h7);
    check("e_irq", {31'b0, irq0}, 32'd1);

    // Stopping on a tick edge: that tick still counts, then TL holds.
    do_reset();
    wr(0, A_TL, 32'h5);
    wr(0, A_TCON, 32'h1);
    chk_rd("f_tl_start", 0, A_TL, 32'h5);
    wr(0, A_TCON, 32'h0);
    chk_rd("f_tl_lasttick", 0, A_TL, 32'h6);
    @(negedge clk);
    @(negedge clk);
    chk_rd("f_tl_hold", 0, A_TL, 32'h6);

    // PRESCALE=4: one TL increment per four cycles.
    do_reset();
    wr(1, A_TCON, 32'h1);
    for (int n = 2; n <= 9; n++) begin
      logic [31:0] exp_tl;
      @(negedge clk);
      exp_tl = (n >= 9) ? 32'd2 : (n >= 5) ? 32'd1 : 32'd0;
      chk_rd($sformatf("g_tl_n%0d", n), 1, A_TL, exp_tl);
    end
    wr(1, A_TCON, 32'h0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk_rd("g_tl_stopped", 1, A_TL, 32'd2);
    // Restart: a full four-cycle interval proves the prescaler was cleared.
    wr(1, A_TCON, 32'h1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk_rd("g_tl_restart_hold", 1, A_TL, 32'd2);
    @(negedge clk);
    chk_rd("g_tl_restart_tick", 1, A_TL, 32'd3);
    wr(1, A_TCON, 32'h0);

    // Asynchronous reset mid-cycle while interrupting and counting.
    wr(0, A_TH, 32'hFFFF_FFFC);
    wr(0, A_TL, 32'hFFFF_FFFF);
    wr(0, A_TCON, 32'h3);
    @(negedge clk);
    check("h_irq_before", {31'b0, irq0}, 32'd1);
    #1 rst = 1'b1;
    #1 check("h_irq_async", {31'b0, irq0}, 32'd0);
    chk_rd("h_tl_async", 0, A_TL, 32'h0);
    chk_rd("h_tcon_async", 0, A_TCON, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_rd("h_tl_idle", 0, A_TL, 32'h0);
    wr(0, A_TCON, 32'h1);
    chk_rd("h_tl_runstart", 0, A_TL, 32'h0);
    @(negedge clk);
    chk_rd("h_tl_counting", 0, A_TL, 32'h1);

    // Final report.
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
